// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans a shadowed attribute table for sprites that hit
// the requested line, then streams their 32-pixel rows from the sprite ROM into a line buffer.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 20,
  parameter int SLOTS       = 4,
  parameter int H_ACTIVE    = 640
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [511:0] i_gl_input,
  input  logic         i_write,
  input  logic         i_line_req,
  input  logic [9:0]   i_next_line,
  output logic [9:0]   o_rom_addr,
  output logic [3:0]   o_rom_sel,
  input  logic [23:0]  i_rom_q,
  output logic         o_lb_we,
  output logic [9:0]   o_lb_addr,
  output logic [23:0]  o_lb_data,
  output logic         o_busy,
  output logic         o_done,
  output logic [2:0]   o_sprite_count,
  output logic         o_overflow,
  output logic         o_overrun
);

  localparam int          TBW       = 24 * NUM_SPRITES;
  localparam int          SW        = $clog2(SLOTS);
  localparam logic [2:0]  MAX_SLOTS = 3'(SLOTS);
  localparam logic [4:0]  LAST_IDX  = 5'(NUM_SPRITES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [TBW-1:0]   r_shadow;
  logic [TBW-1:0]   r_pending;
  logic             r_pend_vld;
  logic [9:0]       r_line;
  logic [4:0]       r_scan_idx;
  logic [2:0]       r_nslots;
  logic [4:0]       r_slot_row [SLOTS];
  logic [3:0]       r_slot_id  [SLOTS];
  logic [9:0]       r_slot_x   [SLOTS];
  logic [SW-1:0]    r_cur_slot;
  logic [4:0]       r_col;
  logic [9:0]       r_rom_addr;
  logic [3:0]       r_rom_sel;
  logic [10:0]      r_addr_x;
  logic             r_addr_vld;
  logic [10:0]      r_wr_x;
  logic             r_wr_vld;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_count;
  logic             r_overflow;

  logic [23:0]      w_entries [NUM_SPRITES];
  logic [23:0]      w_entry;
  logic [10:0]      w_diff;
  logic             w_visible;
  logic             w_take;
  logic [2:0]       w_nslots_after;
  logic [2:0]       w_top;
  logic [SW-1:0]    w_f_slot;
  logic [4:0]       w_f_col;
  logic [4:0]       w_f_row;
  logic [3:0]       w_f_id;
  logic [9:0]       w_f_x;
  logic             w_fetch_last;
  logic             w_lb_we;
  logic             w_unused_hi;

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_entry
    assign w_entries[gi] = r_shadow[24*gi +: 24];
  end

  assign w_unused_hi = ^i_gl_input[511:TBW];

  // Unsigned 11-bit difference: rows above the sprite top wrap to large values.
  assign w_entry        = w_entries[r_scan_idx];
  assign w_diff         = {1'b0, r_line} - {2'b0, w_entry[18:10]};
  assign w_visible      = w_entry[23] && (w_diff < 11'd32);
  assign w_take         = w_visible && (r_nslots < MAX_SLOTS);
  assign w_nslots_after = r_nslots + {2'b0, w_take};
  assign w_top          = w_nslots_after - 3'd1;
  assign w_fetch_last   = (r_col == 5'd31) && (r_cur_slot == '0);

  // Next ROM target; at the end of SCAN the top slot may be the entry being stored this cycle.
  always_comb begin
    w_f_slot = r_cur_slot;
    w_f_col  = r_col + 5'd1;
    if (r_state == S_SCAN) begin
      w_f_slot = w_top[SW-1:0];
      w_f_col  = 5'd0;
    end else if (r_col == 5'd31) begin
      w_f_slot = r_cur_slot - 1'b1;
    end
    w_f_row = r_slot_row[w_f_slot];
    w_f_id  = r_slot_id[w_f_slot];
    w_f_x   = r_slot_x[w_f_slot];
    if ((r_state == S_SCAN) && w_take) begin
      w_f_row = w_diff[4:0];
      w_f_id  = w_entry[22:19];
      w_f_x   = w_entry[9:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow   <= '0;
      r_pending  <= '0;
      r_pend_vld <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (i_write) r_shadow <= i_gl_input[TBW-1:0];
    end else if (r_state == S_DONE) begin
      if (i_write) r_shadow <= i_gl_input[TBW-1:0];
      else if (r_pend_vld) r_shadow <= r_pending;
      r_pend_vld <= 1'b0;
    end else if (i_write) begin
      r_pending  <= i_gl_input[TBW-1:0];
      r_pend_vld <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_scan_idx <= '0;
      r_nslots   <= '0;
      r_cur_slot <= '0;
      r_col      <= '0;
      r_rom_addr <= '0;
      r_rom_sel  <= '0;
      r_addr_x   <= '0;
      r_addr_vld <= 1'b0;
      r_wr_x     <= '0;
      r_wr_vld   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        r_slot_row[i] <= '0;
        r_slot_id[i]  <= '0;
        r_slot_x[i]   <= '0;
      end
    end else begin
      r_wr_vld <= r_addr_vld;
      r_wr_x   <= r_addr_x;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_line_req) begin
            r_state    <= S_SCAN;
            r_busy     <= 1'b1;
            r_line     <= i_next_line;
            r_scan_idx <= '0;
            r_nslots   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_take) begin
            r_slot_row[r_nslots[SW-1:0]] <= w_diff[4:0];
            r_slot_id[r_nslots[SW-1:0]]  <= w_entry[22:19];
            r_slot_x[r_nslots[SW-1:0]]   <= w_entry[9:0];
          end
          if (w_visible && !w_take) r_overflow <= 1'b1;
          r_nslots   <= w_nslots_after;
          r_scan_idx <= r_scan_idx + 5'd1;
          if (r_scan_idx == LAST_IDX) begin
            if (w_nslots_after != 3'd0) begin
              r_state    <= S_FETCH;
              r_addr_vld <= 1'b1;
              r_cur_slot <= w_f_slot;
              r_col      <= w_f_col;
              r_rom_addr <= {w_f_row, w_f_col};
              r_rom_sel  <= w_f_id;
              r_addr_x   <= {1'b0, w_f_x} + {6'b0, w_f_col};
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (w_fetch_last) begin
            r_state    <= S_DRAIN;
            r_addr_vld <= 1'b0;
            r_rom_addr <= '0;
            r_rom_sel  <= '0;
          end else begin
            r_cur_slot <= w_f_slot;
            r_col      <= w_f_col;
            r_rom_addr <= {w_f_row, w_f_col};
            r_rom_sel  <= w_f_id;
            r_addr_x   <= {1'b0, w_f_x} + {6'b0, w_f_col};
          end
        end
        S_DRAIN: r_state <= S_DONE;
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_count <= r_nslots;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write stage pairs the delayed column with the ROM word returned this cycle.
  assign w_lb_we        = r_wr_vld && (i_rom_q != 24'h000000) && (r_wr_x < 11'(H_ACTIVE));
  assign o_lb_we        = w_lb_we;
  assign o_lb_addr      = w_lb_we ? r_wr_x[9:0] : 10'd0;
  assign o_lb_data      = w_lb_we ? i_rom_q : 24'd0;
  assign o_rom_addr     = r_rom_addr;
  assign o_rom_sel      = r_rom_sel;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_sprite_count = r_count;
  assign o_overflow     = r_overflow;
  assign o_overrun      = i_line_req && (r_state != S_IDLE);

endmodule
